// File: rtl/alu_pkg.sv
// Shared opcode encodings, issuer FSM states and response flag layout.
// Response flags are packed {carryout, overflow, zero}.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADDU = 3'b000,
        ALU_ADDS = 3'b001,
        ALU_SUBU = 3'b010,
        ALU_SUBS = 3'b011,
        ALU_AND  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_XOR  = 3'b110,
        ALU_SHR  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE
    } issuer_state_t;

    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_OVF    = 1;
    localparam int FLAG_CARRY  = 2;
    localparam int NUM_FLAGS   = 3;
    localparam int OP_W        = 3;
    localparam int ERR_COUNT_W = 8;

    function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic carry,
                                                        input logic ovf,
                                                        input logic zero);
        return {carry, ovf, zero};
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Response queue: first-word-fall-through FIFO, pointers carry an extra wrap bit
// so full and empty are distinguishable. DEPTH must be a power of 2, at least 2.
module alu_rsp_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to a fixed-latency external ALU and queues the results.
// Define ALU_ERR_COUNT_EN to add the saturating overflow counter output err_count.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int NUMBITS   = 8,
    parameter int ALU_LAT   = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [NUMBITS-1:0] cmd_a,
    input  logic [NUMBITS-1:0] cmd_b,
    input  logic [2:0]         cmd_opcode,
    output logic [NUMBITS-1:0] alu_A,
    output logic [NUMBITS-1:0] alu_B,
    output logic [2:0]         alu_opcode,
    input  logic [NUMBITS-1:0] alu_result,
    input  logic               alu_carryout,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [NUMBITS-1:0] rsp_result,
    output logic [2:0]         rsp_flags,
    output logic [2:0]         rsp_opcode
`ifdef ALU_ERR_COUNT_EN
    ,
    output logic [ERR_COUNT_W-1:0] err_count
`endif
);

    localparam int          RSP_W    = OP_W + NUMBITS + NUM_FLAGS;
    localparam logic [2:0]  LAT_INIT = 3'(ALU_LAT);

    issuer_state_t      state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [NUMBITS-1:0] alu_a_q, alu_b_q;
    alu_op_t            alu_op_q;
    logic               load;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [RSP_W-1:0]   push_data;
    logic [RSP_W-1:0]   head;

    // Both handshakes are forced low while reset is held.
    assign cmd_ready  = reset && (state_q == ST_IDLE) && !fifo_full;
    assign rsp_valid  = reset && !fifo_empty;
    assign pop        = rsp_valid && rsp_ready;

    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign alu_opcode = alu_op_q;

    assign push_data  = {alu_op_q, alu_result, pack_flags(alu_carryout, alu_overflow, alu_zero)};
    assign rsp_opcode = head[RSP_W-1 -: OP_W];
    assign rsp_result = head[NUM_FLAGS +: NUMBITS];
    assign rsp_flags  = head[NUM_FLAGS-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    load    = 1'b1;
                    cnt_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // WAIT lasts ALU_LAT cycles so the ALU output has settled by CAPTURE.
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_CAPTURE: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= ALU_ADDU;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                alu_a_q  <= cmd_a;
                alu_b_q  <= cmd_b;
                alu_op_q <= alu_op_t'(cmd_opcode);
            end
        end
    end

    alu_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

`ifdef ALU_ERR_COUNT_EN
    logic [ERR_COUNT_W-1:0] err_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_count_q <= '0;
        end else if (push && alu_overflow && (err_count_q != '1)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule
